// File: rtl/tl_ul_a_arbiter.sv
// TileLink-UL A-channel arbiter: N clients onto one slave port, round-robin
// with burst locking, per-client outstanding limit and D-channel routing.
module tl_ul_a_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned SRC_W     = 8,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_REQ-1:0]                 in_a_valid,
  output logic [N_REQ-1:0]                 in_a_ready,
  input  logic [3*N_REQ-1:0]               in_a_opcode,
  input  logic [3*N_REQ-1:0]               in_a_param,
  input  logic [3*N_REQ-1:0]               in_a_size,
  input  logic [SRC_W*N_REQ-1:0]           in_a_source,
  input  logic [30*N_REQ-1:0]              in_a_address,
  input  logic [4*N_REQ-1:0]               in_a_mask,
  input  logic [32*N_REQ-1:0]              in_a_data,
  output logic                             out_a_valid,
  input  logic                             out_a_ready,
  output logic [2:0]                       out_a_opcode,
  output logic [2:0]                       out_a_param,
  output logic [2:0]                       out_a_size,
  output logic [SRC_W+$clog2(N_REQ)-1:0]   out_a_source,
  output logic [29:0]                      out_a_address,
  output logic [3:0]                       out_a_mask,
  output logic [31:0]                      out_a_data,
  input  logic                             out_d_valid,
  output logic                             out_d_ready,
  input  logic [2:0]                       out_d_opcode,
  input  logic [2:0]                       out_d_size,
  input  logic [SRC_W+$clog2(N_REQ)-1:0]   out_d_source,
  input  logic [31:0]                      out_d_data,
  input  logic                             out_d_denied,
  input  logic                             out_d_corrupt,
  output logic [N_REQ-1:0]                 in_d_valid,
  input  logic [N_REQ-1:0]                 in_d_ready,
  output logic [2:0]                       in_d_opcode,
  output logic [2:0]                       in_d_size,
  output logic [SRC_W-1:0]                 in_d_source,
  output logic [31:0]                      in_d_data,
  output logic                             in_d_denied,
  output logic                             in_d_corrupt,
  output logic                             err_unexpected_d
);

  localparam int unsigned IDX_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned BEAT_W = 6;

  localparam logic [2:0] OP_PUT_FULL    = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
  localparam logic [2:0] OP_ACK_DATA    = 3'd1;

  // Beats in a transaction: multi-beat only when the opcode carries data and size exceeds the bus
  function automatic logic [BEAT_W-1:0] beats_of(input logic multi, input logic [2:0] size);
    if (multi && (size > 3'd2)) return BEAT_W'(1) << (size - 3'd2);
    return BEAT_W'(1);
  endfunction

  logic [IDX_W-1:0]  last_grant_q, last_grant_d;
  logic [IDX_W-1:0]  lock_idx_q, lock_idx_d;
  logic              lock_q, lock_d;
  logic [BEAT_W-1:0] a_beat_q, a_beat_d;
  logic [BEAT_W-1:0] d_beat_q, d_beat_d;
  logic [CNT_W-1:0]  outst_q [N_REQ];
  logic [CNT_W-1:0]  outst_d [N_REQ];
  logic              err_q, err_d;

  logic [N_REQ-1:0]  eligible;
  logic [IDX_W-1:0]  gnt, cand;
  logic              gnt_valid, found;
  logic              a_fire, a_last, d_fire, d_last;
  logic [BEAT_W-1:0] a_beats, d_beats;
  logic [IDX_W-1:0]  d_idx;

  // Round-robin pick from last_grant+1, or the held index while a burst is locked
  always_comb begin
    eligible  = '0;
    gnt       = last_grant_q;
    gnt_valid = 1'b0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = in_a_valid[i] && (outst_q[i] < CNT_W'(MAX_OUTST));
    end
    if (lock_q) begin
      gnt       = lock_idx_q;
      gnt_valid = in_a_valid[lock_idx_q];
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        cand = last_grant_q + IDX_W'(k + 1);
        if (!found && eligible[cand]) begin
          gnt   = cand;
          found = 1'b1;
        end
      end
      gnt_valid = found;
    end
  end

  // A-channel mux of the granted client and per-client ready
  always_comb begin
    out_a_valid   = gnt_valid;
    out_a_opcode  = in_a_opcode[32'(gnt)*3 +: 3];
    out_a_param   = in_a_param[32'(gnt)*3 +: 3];
    out_a_size    = in_a_size[32'(gnt)*3 +: 3];
    out_a_source  = {gnt, in_a_source[32'(gnt)*SRC_W +: SRC_W]};
    out_a_address = in_a_address[32'(gnt)*30 +: 30];
    out_a_mask    = in_a_mask[32'(gnt)*4 +: 4];
    out_a_data    = in_a_data[32'(gnt)*32 +: 32];
    in_a_ready    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      in_a_ready[i] = out_a_ready && gnt_valid && (gnt == IDX_W'(i));
    end
  end

  // D-channel routing by the grant index carried in the upper source bits
  always_comb begin
    d_idx        = out_d_source[SRC_W +: IDX_W];
    in_d_valid   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      in_d_valid[i] = out_d_valid && (d_idx == IDX_W'(i));
    end
    out_d_ready  = in_d_ready[d_idx];
    in_d_opcode  = out_d_opcode;
    in_d_size    = out_d_size;
    in_d_source  = out_d_source[SRC_W-1:0];
    in_d_data    = out_d_data;
    in_d_denied  = out_d_denied;
    in_d_corrupt = out_d_corrupt;
  end

  // A burst tracking: lock on the first beat of a multi-beat put, release on its last
  always_comb begin
    a_fire       = out_a_valid && out_a_ready;
    a_beats      = beats_of((out_a_opcode == OP_PUT_FULL) || (out_a_opcode == OP_PUT_PARTIAL),
                            out_a_size);
    lock_d       = lock_q;
    lock_idx_d   = lock_idx_q;
    a_beat_d     = a_beat_q;
    last_grant_d = last_grant_q;
    a_last       = 1'b0;
    if (a_fire) begin
      if (lock_q) begin
        a_beat_d = a_beat_q - BEAT_W'(1);
        if (a_beat_q == BEAT_W'(1)) begin
          a_last = 1'b1;
          lock_d = 1'b0;
        end
      end else if (a_beats == BEAT_W'(1)) begin
        a_last = 1'b1;
      end else begin
        lock_d     = 1'b1;
        lock_idx_d = gnt;
        a_beat_d   = a_beats - BEAT_W'(1);
      end
      if (a_last) last_grant_d = gnt;
    end
  end

  // D burst tracking: count beats of a multi-beat AccessAckData
  always_comb begin
    d_fire   = out_d_valid && out_d_ready;
    d_beats  = beats_of(out_d_opcode == OP_ACK_DATA, out_d_size);
    d_beat_d = d_beat_q;
    d_last   = 1'b0;
    if (d_fire) begin
      if (d_beat_q == d_beats - BEAT_W'(1)) begin
        d_last   = 1'b1;
        d_beat_d = '0;
      end else begin
        d_beat_d = d_beat_q + BEAT_W'(1);
      end
    end
  end

  // Outstanding counters; a response with nothing in flight raises the sticky error
  always_comb begin
    err_d = err_q;
    for (int i = 0; i < N_REQ; i++) begin
      outst_d[i] = outst_q[i];
      if (a_last && (gnt == IDX_W'(i)) && !(d_last && (d_idx == IDX_W'(i)))) begin
        outst_d[i] = outst_q[i] + CNT_W'(1);
      end else if (d_last && (d_idx == IDX_W'(i)) && !(a_last && (gnt == IDX_W'(i)))) begin
        if (outst_q[i] == '0) err_d = 1'b1;
        else                  outst_d[i] = outst_q[i] - CNT_W'(1);
      end
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= IDX_W'(N_REQ - 1);
      lock_idx_q   <= '0;
      lock_q       <= 1'b0;
      a_beat_q     <= '0;
      d_beat_q     <= '0;
      err_q        <= 1'b0;
      for (int i = 0; i < N_REQ; i++) outst_q[i] <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      lock_idx_q   <= lock_idx_d;
      lock_q       <= lock_d;
      a_beat_q     <= a_beat_d;
      d_beat_q     <= d_beat_d;
      err_q        <= err_d;
      for (int i = 0; i < N_REQ; i++) outst_q[i] <= outst_d[i];
    end
  end

  assign err_unexpected_d = err_q;

endmodule

// File: tb/tb_tl_ul_a_arbiter.sv
// Scoreboard bench for tl_ul_a_arbiter: directed stimulus pushes expected
// A/D beats, negedge monitors pop and compare whenever a beat is presented.
module tb_tl_ul_a_arbiter;
  localparam int unsigned N_REQ = 4;
  localparam int unsigned SRC_W = 8;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [N_REQ-1:0]     in_a_valid, in_a_ready;
  logic [3*N_REQ-1:0]   in_a_opcode, in_a_param, in_a_size;
  logic [SRC_W*N_REQ-1:0] in_a_source;
  logic [30*N_REQ-1:0]  in_a_address;
  logic [4*N_REQ-1:0]   in_a_mask;
  logic [32*N_REQ-1:0]  in_a_data;
  logic                 out_a_valid, out_a_ready;
  logic [2:0]           out_a_opcode, out_a_param, out_a_size;
  logic [9:0]           out_a_source;
  logic [29:0]          out_a_address;
  logic [3:0]           out_a_mask;
  logic [31:0]          out_a_data;
  logic                 out_d_valid, out_d_ready;
  logic [2:0]           out_d_opcode, out_d_size;
  logic [9:0]           out_d_source;
  logic [31:0]          out_d_data;
  logic                 out_d_denied, out_d_corrupt;
  logic [N_REQ-1:0]     in_d_valid, in_d_ready;
  logic [2:0]           in_d_opcode, in_d_size;
  logic [SRC_W-1:0]     in_d_source;
  logic [31:0]          in_d_data;
  logic                 in_d_denied, in_d_corrupt;
  logic                 err_unexpected_d;

  tl_ul_a_arbiter #(.N_REQ(4), .SRC_W(8), .MAX_OUTST(4)) dut (
    .clock(clock), .reset(reset),
    .in_a_valid(in_a_valid), .in_a_ready(in_a_ready),
    .in_a_opcode(in_a_opcode), .in_a_param(in_a_param), .in_a_size(in_a_size),
    .in_a_source(in_a_source), .in_a_address(in_a_address),
    .in_a_mask(in_a_mask), .in_a_data(in_a_data),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready),
    .out_a_opcode(out_a_opcode), .out_a_param(out_a_param), .out_a_size(out_a_size),
    .out_a_source(out_a_source), .out_a_address(out_a_address),
    .out_a_mask(out_a_mask), .out_a_data(out_a_data),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready),
    .out_d_opcode(out_d_opcode), .out_d_size(out_d_size), .out_d_source(out_d_source),
    .out_d_data(out_d_data), .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .in_d_valid(in_d_valid), .in_d_ready(in_d_ready),
    .in_d_opcode(in_d_opcode), .in_d_size(in_d_size), .in_d_source(in_d_source),
    .in_d_data(in_d_data), .in_d_denied(in_d_denied), .in_d_corrupt(in_d_corrupt),
    .err_unexpected_d(err_unexpected_d)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0]  src;
    logic [29:0] addr;
    logic [31:0] data;
    logic [2:0]  opcode;
  } a_exp_t;

  typedef struct packed {
    logic [3:0]  vld;
    logic [7:0]  src;
    logic [31:0] data;
    logic [2:0]  opcode;
  } d_exp_t;

  a_exp_t a_q[$];
  d_exp_t d_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // A monitor: every accepted beat must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && out_a_valid && out_a_ready) begin
      if (a_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL a_unexpected_fire actual_src=%0h required=none", out_a_source);
      end else begin
        a_exp_t e;
        e = a_q.pop_front();
        check("a_source", 64'(out_a_source), 64'(e.src));
        check("a_address", 64'(out_a_address), 64'(e.addr));
        check("a_data", 64'(out_a_data), 64'(e.data));
        check("a_opcode", 64'(out_a_opcode), 64'(e.opcode));
      end
    end
  end

  // D monitor: every routed response must match the head of the expected queue
  always @(negedge clock) begin
    if (!reset && (in_d_valid != '0)) begin
      if (d_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d_unexpected_valid actual=%0h required=0", in_d_valid);
      end else begin
        d_exp_t e;
        e = d_q.pop_front();
        check("d_valid_route", 64'(in_d_valid), 64'(e.vld));
        check("d_source", 64'(in_d_source), 64'(e.src));
        check("d_data", 64'(in_d_data), 64'(e.data));
        check("d_opcode", 64'(in_d_opcode), 64'(e.opcode));
        check("d_ready_route", 64'(out_d_ready), 64'(1));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic set_a(input int i, input logic [2:0] op, input logic [2:0] sz,
                       input logic [7:0] src, input logic [29:0] addr, input logic [31:0] data);
    in_a_valid[i]            = 1'b1;
    in_a_opcode[3*i +: 3]    = op;
    in_a_param[3*i +: 3]     = 3'd0;
    in_a_size[3*i +: 3]      = sz;
    in_a_source[8*i +: 8]    = src;
    in_a_address[30*i +: 30] = addr;
    in_a_mask[4*i +: 4]      = 4'hF;
    in_a_data[32*i +: 32]    = data;
  endtask

  task automatic clr_a(input int i);
    in_a_valid[i] = 1'b0;
  endtask

  task automatic push_a(input int i, input logic [2:0] op, input logic [7:0] src,
                        input logic [29:0] addr, input logic [31:0] data);
    a_exp_t e;
    e.src    = {2'(i), src};
    e.addr   = addr;
    e.data   = data;
    e.opcode = op;
    a_q.push_back(e);
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [2:0] sz,
                         input logic [9:0] src, input logic [31:0] data);
    d_exp_t e;
    out_d_valid  = 1'b1;
    out_d_opcode = op;
    out_d_size   = sz;
    out_d_source = src;
    out_d_data   = data;
    e.vld    = 4'(1) << src[9:8];
    e.src    = src[7:0];
    e.data   = data;
    e.opcode = op;
    d_q.push_back(e);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    in_a_valid    = '0;
    in_a_opcode   = '0;
    in_a_param    = '0;
    in_a_size     = '0;
    in_a_source   = '0;
    in_a_address  = '0;
    in_a_mask     = '0;
    in_a_data     = '0;
    out_a_ready   = 1'b0;
    out_d_valid   = 1'b0;
    out_d_opcode  = '0;
    out_d_size    = '0;
    out_d_source  = '0;
    out_d_data    = '0;
    out_d_denied  = 1'b0;
    out_d_corrupt = 1'b0;
    in_d_ready    = '0;
    repeat (2) cyc();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clock);
    check("rst_out_a_valid", 64'(out_a_valid), 64'(0));
    check("rst_in_a_ready", 64'(in_a_ready), 64'(0));
    check("rst_in_d_valid", 64'(in_d_valid), 64'(0));
    check("rst_out_d_ready", 64'(out_d_ready), 64'(0));
    check("rst_err", 64'(err_unexpected_d), 64'(0));
    cyc();

    // Clients 0 and 2 alternate under round robin
    out_a_ready = 1'b1;
    in_d_ready  = '1;
    set_a(0, 3'd4, 3'd2, 8'h11, 30'h1000, 32'hA0);
    set_a(2, 3'd4, 3'd2, 8'h22, 30'h2000, 32'hA2);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_a(0, 3'd4, 8'h11, 30'h1000, 32'hA0);
      else            push_a(2, 3'd4, 8'h22, 30'h2000, 32'hA2);
      @(negedge clock);
      cyc();
    end
    clr_a(0);
    clr_a(2);
    @(negedge clock);
    cyc();

    // 4-beat PutFull on client 1 holds the grant against client 3
    do_reset();
    out_a_ready = 1'b1;
    in_d_ready  = '1;
    set_a(3, 3'd4, 3'd2, 8'h33, 30'h3000, 32'hA3);
    for (int k = 0; k < 4; k++) begin
      set_a(1, 3'd0, 3'd4, 8'h44, 30'h1100, 32'hB0 + 32'(k));
      push_a(1, 3'd0, 8'h44, 30'h1100, 32'hB0 + 32'(k));
      @(negedge clock);
      check("burst_ready3_low", 64'(in_a_ready[3]), 64'(0));
      cyc();
    end
    clr_a(1);
    push_a(3, 3'd4, 8'h33, 30'h3000, 32'hA3);
    @(negedge clock);
    check("after_burst_ready3", 64'(in_a_ready[3]), 64'(1));
    cyc();
    clr_a(3);
    @(negedge clock);
    cyc();

    // Outstanding limit on client 0, released by single- and multi-beat responses
    do_reset();
    out_a_ready = 1'b1;
    in_d_ready  = '1;
    for (int k = 0; k < 4; k++) begin
      set_a(0, 3'd4, 3'd2, 8'h05, 30'h4000 + 30'(k), 32'hC0 + 32'(k));
      push_a(0, 3'd4, 8'h05, 30'h4000 + 30'(k), 32'hC0 + 32'(k));
      @(negedge clock);
      cyc();
    end
    set_a(0, 3'd4, 3'd2, 8'h05, 30'h4004, 32'hC4);
    @(negedge clock);
    check("limit_ready0", 64'(in_a_ready[0]), 64'(0));
    check("limit_out_valid", 64'(out_a_valid), 64'(0));
    cyc();
    drive_d(3'd1, 3'd2, 10'h005, 32'hDD00);
    @(negedge clock);
    check("limit_ready0_during_d", 64'(in_a_ready[0]), 64'(0));
    cyc();
    out_d_valid = 1'b0;
    push_a(0, 3'd4, 8'h05, 30'h4004, 32'hC4);
    @(negedge clock);
    cyc();
    set_a(0, 3'd4, 3'd2, 8'h05, 30'h4005, 32'hC5);
    @(negedge clock);
    check("limit_again_ready0", 64'(in_a_ready[0]), 64'(0));
    cyc();
    drive_d(3'd1, 3'd3, 10'h005, 32'hDD01);
    @(negedge clock);
    cyc();
    drive_d(3'd1, 3'd3, 10'h005, 32'hDD02);
    @(negedge clock);
    check("d_first_beat_no_release", 64'(in_a_ready[0]), 64'(0));
    cyc();
    out_d_valid = 1'b0;
    push_a(0, 3'd4, 8'h05, 30'h4005, 32'hC5);
    @(negedge clock);
    cyc();
    clr_a(0);
    @(negedge clock);
    cyc();

    // Simultaneous increment and decrement on client 2 leaves the count at 3
    do_reset();
    out_a_ready = 1'b1;
    in_d_ready  = '1;
    for (int k = 0; k < 3; k++) begin
      set_a(2, 3'd4, 3'd2, 8'h22, 30'h5000 + 30'(k), 32'hE0 + 32'(k));
      push_a(2, 3'd4, 8'h22, 30'h5000 + 30'(k), 32'hE0 + 32'(k));
      @(negedge clock);
      cyc();
    end
    set_a(2, 3'd4, 3'd2, 8'h22, 30'h5003, 32'hE3);
    push_a(2, 3'd4, 8'h22, 30'h5003, 32'hE3);
    drive_d(3'd0, 3'd2, 10'h222, 32'h0);
    @(negedge clock);
    cyc();
    out_d_valid = 1'b0;
    set_a(2, 3'd4, 3'd2, 8'h22, 30'h5004, 32'hE4);
    push_a(2, 3'd4, 8'h22, 30'h5004, 32'hE4);
    @(negedge clock);
    check("simul_ready2_accepts", 64'(in_a_ready[2]), 64'(1));
    cyc();
    set_a(2, 3'd4, 3'd2, 8'h22, 30'h5005, 32'hE5);
    @(negedge clock);
    check("simul_then_limit_ready2", 64'(in_a_ready[2]), 64'(0));
    cyc();
    clr_a(2);
    @(negedge clock);
    cyc();

    // Unexpected response to idle client 3: sticky error, counter stays 0
    do_reset();
    out_a_ready = 1'b1;
    in_d_ready  = '1;
    drive_d(3'd0, 3'd2, 10'h3AB, 32'h1234);
    @(negedge clock);
    check("err_before_edge", 64'(err_unexpected_d), 64'(0));
    cyc();
    out_d_valid = 1'b0;
    @(negedge clock);
    check("err_set", 64'(err_unexpected_d), 64'(1));
    repeat (3) cyc();
    @(negedge clock);
    check("err_sticky", 64'(err_unexpected_d), 64'(1));
    cyc();
    for (int k = 0; k < 4; k++) begin
      set_a(3, 3'd4, 3'd2, 8'h30, 30'h6000 + 30'(k), 32'hF0 + 32'(k));
      push_a(3, 3'd4, 8'h30, 30'h6000 + 30'(k), 32'hF0 + 32'(k));
      @(negedge clock);
      check("c3_count_from_zero", 64'(in_a_ready[3]), 64'(1));
      cyc();
    end
    set_a(3, 3'd4, 3'd2, 8'h30, 30'h6004, 32'hF4);
    @(negedge clock);
    check("c3_limit_ready3", 64'(in_a_ready[3]), 64'(0));
    cyc();
    clr_a(3);

    // Reset mid-burst drops the lock; client 0 wins the next grant
    do_reset();
    out_a_ready = 1'b1;
    in_d_ready  = '1;
    for (int k = 0; k < 2; k++) begin
      set_a(1, 3'd0, 3'd4, 8'h66, 30'h7000, 32'h70 + 32'(k));
      push_a(1, 3'd0, 8'h66, 30'h7000, 32'h70 + 32'(k));
      @(negedge clock);
      cyc();
    end
    reset       = 1'b1;
    out_a_ready = 1'b0;
    set_a(1, 3'd0, 3'd4, 8'h66, 30'h7000, 32'h72);
    set_a(0, 3'd4, 3'd2, 8'h07, 30'h7100, 32'h80);
    @(negedge clock);
    cyc();
    reset       = 1'b0;
    out_a_ready = 1'b1;
    push_a(0, 3'd4, 8'h07, 30'h7100, 32'h80);
    @(negedge clock);
    check("post_reset_grant_idx", 64'(out_a_source[9:8]), 64'(0));
    check("post_reset_ready1", 64'(in_a_ready[1]), 64'(0));
    cyc();
    clr_a(0);
    clr_a(1);
    @(negedge clock);
    cyc();

    check("a_queue_drained", 64'(a_q.size()), 64'(0));
    check("d_queue_drained", 64'(d_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tl_ul_a_arbiter.md
Name: tl_ul_a_arbiter

Overview:
- Shares one TileLink-UL port (30-bit address, 32-bit data, 10-bit source) between N_REQ client masters.
- Round-robin A-channel arbitration with burst locking, per-client outstanding-request limiting, and D-channel response routing by upper source bits.
- Sits between the client crossbar stubs and the single slave port watched by the existing TL monitor; its output A/D pins connect directly to the monitor's inputs.

Parameters:
- N_REQ, 4, number of clients (power of 2, 2..4); IDX_W = log2(N_REQ).
- SRC_W, 8, client source width; output source width = SRC_W + IDX_W (10 at defaults).
- MAX_OUTST, 4, max in-flight transactions per client (1..15).

Ports:
- clock  in  1  single clock, all logic posedge.
- reset  in  1  synchronous, active-high.
- in_a_valid / in_a_ready  in / out  N_REQ  per-client A handshake.
- in_a_opcode, in_a_param, in_a_size  in  3*N_REQ each  packed, client i at [3i+2:3i].
- in_a_source  in  SRC_W*N_REQ  client source.
- in_a_address  in  30*N_REQ  byte address.
- in_a_mask  in  4*N_REQ  byte mask.
- in_a_data  in  32*N_REQ  write data.
- out_a_valid / out_a_ready  out / in  1  shared A handshake.
- out_a_opcode, out_a_param, out_a_size  out  3 each  selected client fields.
- out_a_source  out  SRC_W+IDX_W  {grant index, client source}.
- out_a_address / out_a_mask / out_a_data  out  30 / 4 / 32  selected client fields.
- out_d_valid / out_d_ready  in / out  1  shared D handshake.
- out_d_opcode / out_d_size / out_d_source  in  3 / 3 / SRC_W+IDX_W  D fields.
- out_d_data / out_d_denied / out_d_corrupt  in  32 / 1 / 1  D fields.
- in_d_valid  out  N_REQ  routed D valid.
- in_d_ready  in  N_REQ  per-client D ready.
- in_d_opcode / in_d_size / in_d_source / in_d_data / in_d_denied / in_d_corrupt  out  3 / 3 / SRC_W / 32 / 1 / 1  broadcast to all clients; qualified only by in_d_valid.
- err_unexpected_d  out  1  sticky protocol error flag.

Behaviour:
- Reset values:
  - last_grant = N_REQ-1, so client 0 wins first.
  - lock = 0, beat counters = 0, outstanding counts = 0, err_unexpected_d = 0.
  - All valid and ready outputs are combinationally 0 while counts are 0 and no input is valid.
- Eligibility: client i is eligible when in_a_valid[i] is high and outst[i] < MAX_OUTST.
- Arbitration (combinational, zero latency):
  - When not locked, grant the first eligible client scanning from last_grant+1 modulo N_REQ.
  - out_a_valid = any eligible.
  - in_a_ready[g] = out_a_ready for the granted client only; all others 0.
- Beats per A transaction:
  - Opcode PutFull (0) or PutPartial (1) with size > 2: beats = 1 << (size-2).
  - Otherwise: 1 beat.
- A fire = out_a_valid & out_a_ready.
  - On the first fire of a multi-beat put: set lock and hold the grant index; a_beat counts down.
  - The outstanding limit is not re-evaluated while locked.
- Last A beat fire: clear lock, update last_grant to the granted index, increment outst[g].
- Locked grant with in_a_valid[g] low: out_a_valid = 0, and no other client is granted.
- D routing:
  - idx = out_d_source[top IDX_W bits].
  - in_d_valid[idx] = out_d_valid; out_d_ready = in_d_ready[idx].
  - in_d_source = low SRC_W bits of out_d_source.
- D beats:
  - AccessAckData (1) with size > 2 is multi-beat; d_beat counts the beats.
  - The last D beat fire decrements outst[idx].
- Simultaneous increment and decrement on the same client in one cycle: count unchanged.
- D last beat for a client with outst == 0:
  - Set err_unexpected_d; it stays set until reset.
  - The counter stays at 0, no wrap.
- Reset asserted mid-burst: lock, beat counters and counts clear on the next edge; no partial state survives.
- No combinational path from out_a_ready to out_a_valid.

Test Plan:
- Clients 0 and 2 continuously issue Get size 2, out_a_ready = 1 -> grants alternate 0, 2, 0, 2; out_a_source[9:8] = 0, 2, 0, 2.
- Client 1 issues PutFull size 4 (4 beats) while client 3 is valid -> four consecutive client-1 beats, then client 3; in_a_ready[3] = 0 throughout the burst.
- Client 0 issues 4 Gets with no D responses (MAX_OUTST = 4) -> fifth Get is blocked, in_a_ready[0] = 0; one AccessAckData with source 0x005 -> in_d_valid[0] = 1, in_d_source = 0x05, and the fifth Get is accepted on the following cycle.
- A last-beat fire on client 2 and a D last beat to client 2 in the same cycle, starting from outst = 3 -> outst stays 3.
- D response with source 0x3xx while outst[3] = 0 -> err_unexpected_d = 1 next cycle and remains 1; outst[3] stays 0.
- Reset pulsed during beat 2 of a 4-beat put -> lock clears; the next grant goes to client 0 if it is valid.
